// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte FIFO between uart_rx and an asynchronous CPU read strobe.
// Define UART_RXFIFO_OVERRUN_EN to add the sticky overrun flag and its ovr_clr input.
module uart_rx_fifo #(
    parameter int         DEPTH_LOG2 = 4,
    parameter logic [7:0] EH_REQ     = 8'hCC,
    parameter logic [7:0] EH_ACK     = 8'h33
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_data_ready,
    output logic                  rx_clear,
    input  logic                  rd_sel_n,
    output logic [7:0]            dout,
    output logic [7:0]            hsk,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full
`ifdef UART_RXFIFO_OVERRUN_EN
    ,
    output logic                  overrun,
    input  logic                  ovr_clr
`endif
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
    localparam logic [DEPTH_LOG2:0] CNT_ONE = 1;
    localparam logic [DEPTH_LOG2:0] CNT_FULL = DEPTH;

    typedef enum logic {IDLE, CLEAR} state_t;
    state_t state, state_next;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
    logic                  sync1, sync2, sync3;
    logic                  push, pop, wr_en;
    logic [DEPTH_LOG2:0]   count_next;

    always_comb begin
        push       = (state == IDLE) && rx_data_ready;
        state_next = push ? CLEAR : ((state == CLEAR) && !rx_data_ready) ? IDLE : state;
    end

    // Pop fires on the rising edge of the synchronised strobe, i.e. after the CPU has read dout.
    assign pop        = sync2 && !sync3 && !empty;
    assign wr_en      = push && (!full || pop);
    assign count_next = count + (wr_en ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            sync3  <= 1'b1;
        end else begin
            state  <= state_next;
            sync1  <= rd_sel_n;
            sync2  <= sync1;
            sync3  <= sync2;
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            count  <= count_next;
            empty  <= (count_next == '0);
            full   <= (count_next == CNT_FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && reset_n) mem[wr_ptr] <= rx_data;
    end

`ifdef UART_RXFIFO_OVERRUN_EN
    logic drop;
    assign drop = push && full && !pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) overrun <= 1'b0;
        else if (drop) overrun <= 1'b1;
        else if (ovr_clr) overrun <= 1'b0;
    end
`endif

    assign rx_clear = (state == CLEAR);
    assign dout     = mem[rd_ptr];
    assign hsk      = empty ? EH_REQ : EH_ACK;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: table-driven fill/drain plus directed handshake, pop-timing and reset sequences.
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] rx_data;
    logic       rx_data_ready;
    logic       rx_clear;
    logic       rd_sel_n;
    logic [7:0] dout;
    logic [7:0] hsk;
    logic [4:0] count;
    logic       empty;
    logic       full;
`ifdef UART_RXFIFO_OVERRUN_EN
    logic       overrun;
    logic       ovr_clr;
`endif

    int n_vec = 0;
    int n_bad = 0;

    uart_rx_fifo dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_data_ready(rx_data_ready),
        .rx_clear(rx_clear), .rd_sel_n(rd_sel_n), .dout(dout), .hsk(hsk),
        .count(count), .empty(empty), .full(full)
`ifdef UART_RXFIFO_OVERRUN_EN
        , .overrun(overrun), .ovr_clr(ovr_clr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_pop;
        logic [7:0] data;
        int         exp_count;
        logic       exp_full;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t vecs[33];

    function automatic vec_t mk(logic p, logic [7:0] d, int c, logic f, logic [7:0] o);
        vec_t v;
        v.is_pop = p; v.data = d; v.exp_count = c; v.exp_full = f; v.exp_dout = o;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_push(logic [7:0] b);
        rx_data = b;
        rx_data_ready = 1'b1;
        @(posedge clk); #1;
        rx_data_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_pop();
        rd_sel_n = 1'b0;
        repeat (5) @(posedge clk);
        #1 rd_sel_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_state(string tag, int c, logic [7:0] d);
        check({tag, " count"}, 32'(count), 32'(c));
        check({tag, " empty"}, 32'(empty), 32'(c == 0));
        check({tag, " full"}, 32'(full), 32'(c == 16));
        check({tag, " hsk"}, 32'(hsk), (c == 0) ? 32'hCC : 32'h33);
        if (c != 0) check({tag, " dout"}, 32'(dout), 32'(d));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) vecs[i] = mk(1'b0, 8'(i), i + 1, i == 15, 8'h00);
        vecs[16] = mk(1'b0, 8'hFF, 16, 1'b1, 8'h00);
        for (int k = 1; k <= 16; k++) vecs[16 + k] = mk(1'b1, 8'h00, 16 - k, 1'b0, 8'(k));

        reset_n = 1'b0;
        rx_data = 8'h00;
        rx_data_ready = 1'b0;
        rd_sel_n = 1'b1;
`ifdef UART_RXFIFO_OVERRUN_EN
        ovr_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 0, 8'h00);
        check("reset rx_clear", 32'(rx_clear), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Single push with ready held: one byte only, rx_clear until ready drops
        rx_data = 8'h41;
        rx_data_ready = 1'b1;
        @(posedge clk); #1;
        check("push rx_clear1", 32'(rx_clear), 32'd1);
        check_state("push1", 1, 8'h41);
        @(posedge clk); #1;
        check("push rx_clear2", 32'(rx_clear), 32'd1);
        check("push held count", 32'(count), 32'd1);
        rx_data_ready = 1'b0;
        @(posedge clk); #1;
        check("push rx_clear0", 32'(rx_clear), 32'd0);
        check_state("push done", 1, 8'h41);

        // CPU read: dout stable while strobe low, pop lands on the 3rd edge after release
        rd_sel_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("read stable dout", 32'(dout), 32'h41);
            check("read stable count", 32'(count), 32'd1);
        end
        rd_sel_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("pop edge2 count", 32'(count), 32'd1);
        @(posedge clk); #1;
        check("pop edge3 count", 32'(count), 32'd0);
        check("pop edge3 hsk", 32'(hsk), 32'hCC);

        // Fill to 16, overflow with 8'hFF, drain in order
        for (int i = 0; i < 33; i++) begin
            if (vecs[i].is_pop) do_pop();
            else do_push(vecs[i].data);
            check_state($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_dout);
        end
`ifdef UART_RXFIFO_OVERRUN_EN
        check("overrun set", 32'(overrun), 32'd1);
        ovr_clr = 1'b1;
        @(posedge clk); #1;
        ovr_clr = 1'b0;
        check("overrun clr", 32'(overrun), 32'd0);
`endif

        // Full FIFO, push and pop on the same edge
        for (int i = 0; i < 16; i++) do_push(8'h10 + 8'(i));
        check_state("refill", 16, 8'h10);
        rd_sel_n = 1'b0;
        repeat (4) @(posedge clk);
        #1 rd_sel_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rx_data = 8'hAA;
        rx_data_ready = 1'b1;
        @(posedge clk); #1;
        check_state("push+pop full", 16, 8'h11);
        rx_data_ready = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 15; k++) begin
            do_pop();
            check_state($sformatf("tail pop%0d", k), 15 - k, (k < 14) ? 8'h12 + 8'(k) : 8'hAA);
        end
        do_pop();
        check_state("tail empty", 0, 8'h00);

        // Pop on empty is ignored
        do_pop();
        check_state("empty pop", 0, 8'h00);
        do_push(8'h55);
        check_state("after empty pop", 1, 8'h55);
        do_pop();
        check_state("drain55", 0, 8'h00);

        // Reset during CLEAR with 3 bytes stored
        do_push(8'h01);
        do_push(8'h02);
        rx_data = 8'h03;
        rx_data_ready = 1'b1;
        @(posedge clk); #1;
        check("pre-reset rx_clear", 32'(rx_clear), 32'd1);
        check("pre-reset count", 32'(count), 32'd3);
        #2 reset_n = 1'b0;
        #1;
        check("async rst rx_clear", 32'(rx_clear), 32'd0);
        check_state("async rst", 0, 8'h00);
        rx_data_ready = 1'b0;
        @(posedge clk);
        #3 reset_n = 1'b1;
        rx_data = 8'h77;
        rx_data_ready = 1'b1;
        @(posedge clk); #1;
        rx_data_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_state("post-reset no pop", 1, 8'h77);
        check("post-reset rx_clear", 32'(rx_clear), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, giving FIFO depth of 2**DEPTH_LOG2 bytes.
REQ-002 SHALL have parameter EH_REQ, default 8'hCC, the handshake byte returned when the FIFO is empty.
REQ-003 SHALL have parameter EH_ACK, default 8'h33, the handshake byte returned when the FIFO is not empty.
REQ-004 SHALL have port clk, input, 1 bit: single system clock, sys_clk domain.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port rx_data, input, 8 bits: received byte from uart_rx.
REQ-007 SHALL have port rx_data_ready, input, 1 bit: uart_rx byte-valid level.
REQ-008 SHALL have port rx_clear, output, 1 bit: acknowledge to uart_rx.
REQ-009 SHALL have port rd_sel_n, input, 1 bit: asynchronous CPU read strobe, already qualified by a data-address match, active-low.
REQ-010 SHALL have port dout, output, 8 bits: FIFO head byte (show-ahead).
REQ-011 SHALL have port hsk, output, 8 bits: EH_REQ or EH_ACK status byte.
REQ-012 SHALL have port count, output, DEPTH_LOG2+1 bits: current occupancy.
REQ-013 SHALL have ports empty and full, outputs, 1 bit each: occupancy flags.
REQ-014 SHALL have port overrun, output, 1 bit, present only under UART_RXFIFO_OVERRUN_EN: sticky overrun flag.
REQ-015 SHALL have port ovr_clr, input, 1 bit, present only under UART_RXFIFO_OVERRUN_EN: synchronous clear for overrun.

Function
REQ-016 SHALL run an ingest FSM with two states: IDLE and CLEAR.
REQ-017 SHALL, in IDLE when rx_data_ready=1 at a clk edge, push rx_data at that edge, go to CLEAR, and register rx_clear=1.
REQ-018 SHALL, in CLEAR, hold rx_clear=1 until rx_data_ready is sampled 0, then at that edge set rx_clear=0 and return to IDLE.
REQ-019 SHALL ensure a single uart_rx byte is never pushed twice.
REQ-020 SHALL synchronise rd_sel_n through two flops and pop on the rising edge of the synchronised signal (end of CPU read), so dout remains stable throughout the read.
REQ-021 SHALL apply a pop on the 3rd clk edge after rd_sel_n rises, provided the FIFO is non-empty.
REQ-022 SHALL ignore a pop when empty; pointers and count are unchanged.
REQ-023 SHALL accept a push when not full, or when full and a pop occurs on the same edge.
REQ-024 SHALL, on a simultaneous push and pop, perform both and leave count unchanged.
REQ-025 SHALL, on a push when full without a same-edge pop, drop the byte while still completing the rx_clear handshake (uart_rx never stalls).
REQ-026 SHALL use DEPTH_LOG2-bit read/write pointers wrapping modulo depth; count is exact from 0 to 2**DEPTH_LOG2.
REQ-027 SHALL assert empty exactly when count=0 and full exactly when count=2**DEPTH_LOG2, both registered-consistent with count.
REQ-028 SHALL drive dout from mem[rd_ptr] combinationally; dout is valid the cycle after the push edge into an empty FIFO, and don't-care when empty.
REQ-029 SHALL drive hsk = empty ? EH_REQ : EH_ACK.

Reset
REQ-030 SHALL, while reset_n=0, asynchronously force: state=IDLE, rx_clear=0, pointers=0, count=0, empty=1, full=0, overrun=0, and both sync flops=1 (no spurious pop).
REQ-031 SHALL not reset the memory array contents.
REQ-032 SHALL, on reset mid-handshake, leave uart_rx to be re-handshaked from IDLE after release; no byte is pushed during reset.

Configuration
REQ-033 SHALL, with UART_RXFIFO_OVERRUN_EN defined, set overrun=1 on any dropped byte (REQ-025) and clear it on ovr_clr=1; if set and clear coincide, set wins.
REQ-034 SHALL, without UART_RXFIFO_OVERRUN_EN, omit the overrun and ovr_clr ports and drop bytes silently; all other behaviour is identical.

Verification
REQ-035 SHALL cover: push 8'h41 via rx_data_ready -> rx_clear high until ready drops, count=1, empty=0, dout=8'h41, hsk=8'h33.
REQ-036 SHALL cover: rd_sel_n low for 5 cycles then high with one byte stored -> dout stable while low; count=0 and hsk=8'hCC on the 3rd edge after release.
REQ-037 SHALL cover: push 16 bytes 8'h00..8'h0F, then a 17th byte 8'hFF -> full=1, 8'hFF dropped, overrun=1 (macro on), reads return 8'h00..8'h0F in order.
REQ-038 SHALL cover: full FIFO with push and pop on the same edge -> count stays 16 and the new byte is stored at the tail.
REQ-039 SHALL cover: pop strobe on an empty FIFO -> count=0, pointers unchanged, no underflow.
REQ-040 SHALL cover: reset_n pulsed low during CLEAR with 3 bytes stored -> rx_clear=0, count=0, empty=1 immediately, and no pop after release.
